// File: rtl/fruit_pkg.sv
// fruit_pkg: shared types, screen defaults, FSM encoding and helper functions for the fruit slice sequencer
//   pos_t/vel_t : signed 12b position and signed 8b velocity
//   state_t     : IDLE / WHOLE / SPLIT
//   clamp10     : signed position -> renderer coordinate in [0,1023]
//   off_x       : half lies outside the visible columns [0,w)
package fruit_pkg;
  localparam int POS_W      = 12;
  localparam int VEL_W      = 8;
  localparam int OBJ_W_D    = 64;
  localparam int SCREEN_W_D = 640;
  localparam int SCREEN_H_D = 480;
  localparam int GRAVITY_D  = 1;
  localparam int VY_MAX_D   = 12;
  localparam int SPLIT_V_D  = 2;
  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  localparam vel_t VEL_MIN = 8'sh80;
  localparam vel_t VEL_MAX = 8'sh7f;
  typedef enum logic [1:0] {IDLE = 2'd0, WHOLE = 2'd1, SPLIT = 2'd2} state_t;
  // Bit 10 set on a non-negative 12b value means it exceeds 1023.
  function automatic logic [9:0] clamp10(pos_t v);
    return v[POS_W-1] ? 10'd0 : v[10] ? 10'd1023 : v[9:0];
  endfunction
  function automatic logic off_x(pos_t x, pos_t w);
    return x[POS_W-1] || x >= w;
  endfunction
endpackage

// File: rtl/motion_axis.sv
// motion_axis: signed position/velocity register pair for one axis
//   load_i/pos_ld_i/vel_ld_i : load both registers (wins over everything else)
//   tick_i                   : pos += vel (uses the velocity held before this cycle)
//   dv_en_i/dv_i             : vel += dv, saturated to [VEL_MIN, V_MAX]
//   pos_o                    : registered position
//   pos_nxt_o/vel_nxt_o      : values that will be registered at the next edge
module motion_axis import fruit_pkg::*; #(
  parameter vel_t V_MAX = VEL_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  pos_t pos_ld_i,
  input  vel_t vel_ld_i,
  input  logic tick_i,
  input  logic dv_en_i,
  input  vel_t dv_i,
  output pos_t pos_o,
  output pos_t pos_nxt_o,
  output vel_t vel_nxt_o
);
  pos_t pos_q, pos_d;
  vel_t vel_q, vel_d;
  logic signed [VEL_W:0] sum, hi, lo;
  always_comb begin
    hi = (VEL_W+1)'(V_MAX);
    lo = (VEL_W+1)'(VEL_MIN);
    sum = (VEL_W+1)'(vel_q) + (VEL_W+1)'(dv_i);
    vel_d = load_i ? vel_ld_i : !dv_en_i ? vel_q : sum > hi ? V_MAX : sum < lo ? VEL_MIN : sum[VEL_W-1:0];
    pos_d = load_i ? pos_ld_i : tick_i ? pos_q + POS_W'(vel_q) : pos_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos_q <= '0;
      vel_q <= '0;
    end else begin
      pos_q <= pos_d;
      vel_q <= vel_d;
    end
  assign pos_o     = pos_q;
  assign pos_nxt_o = pos_d;
  assign vel_nxt_o = vel_d;
endmodule

// File: rtl/fruit_slice_sequencer.sv
// fruit_slice_sequencer: per-fruit launch, ballistic motion and cut sequencer driving a two-half sprite renderer
//   frame_tick/launch/cut      : one-cycle control pulses
//   launch_x/vx/vy             : initial left x and signed velocities (negative vy = up)
//   en1/en2, posx1/2, posy1/2  : per-half enable and clamped top-left position
//   busy                       : a fruit is in flight
//   done/missed                : one-cycle retire pulse, missed when retired uncut
module fruit_slice_sequencer import fruit_pkg::*; #(
  parameter int OBJ_W    = OBJ_W_D,
  parameter int SCREEN_W = SCREEN_W_D,
  parameter int SCREEN_H = SCREEN_H_D,
  parameter int GRAVITY  = GRAVITY_D,
  parameter int VY_MAX   = VY_MAX_D,
  parameter int SPLIT_V  = SPLIT_V_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              launch,
  input  logic [9:0]        launch_x,
  input  logic signed [7:0] launch_vx,
  input  logic signed [7:0] launch_vy,
  input  logic              cut,
  output logic              en1,
  output logic              en2,
  output logic [9:0]        posx1,
  output logic [9:0]        posx2,
  output logic [9:0]        posy1,
  output logic [9:0]        posy2,
  output logic              busy,
  output logic              done,
  output logic              missed
);
  localparam pos_t SW   = pos_t'(SCREEN_W);
  localparam pos_t SH   = pos_t'(SCREEN_H);
  localparam pos_t Y0   = pos_t'(SCREEN_H - 1);
  localparam pos_t HALF = pos_t'(OBJ_W >> 1);
  localparam vel_t GV   = vel_t'(GRAVITY);
  localparam vel_t VYM  = vel_t'(VY_MAX);
  localparam vel_t SPP  = vel_t'(SPLIT_V);
  localparam vel_t SPN  = vel_t'(-SPLIT_V);
  state_t state_q, state_d;
  logic done_q, done_d, missed_q, missed_d;
  logic tick_act, ld, split_now, fall, gone, retire;
  pos_t x1_q, x2_q, y_q, x1_n, x2_n, y_n;
  vel_t vx1_n, vx2_n, vy_n;
  logic unused_vx;
  assign unused_vx = ^{vx1_n, vx2_n};
  motion_axis u_x1 (
    .clk(clk), .rst(rst), .load_i(ld), .pos_ld_i(pos_t'(launch_x)), .vel_ld_i(launch_vx),
    .tick_i(tick_act), .dv_en_i(split_now), .dv_i(SPN),
    .pos_o(x1_q), .pos_nxt_o(x1_n), .vel_nxt_o(vx1_n)
  );
  motion_axis u_x2 (
    .clk(clk), .rst(rst), .load_i(ld), .pos_ld_i(pos_t'(launch_x) + HALF), .vel_ld_i(launch_vx),
    .tick_i(tick_act), .dv_en_i(split_now), .dv_i(SPP),
    .pos_o(x2_q), .pos_nxt_o(x2_n), .vel_nxt_o(vx2_n)
  );
  // Gravity is applied as a velocity step on every tick; the position step uses the pre-tick velocity.
  motion_axis #(.V_MAX(VYM)) u_y (
    .clk(clk), .rst(rst), .load_i(ld), .pos_ld_i(Y0), .vel_ld_i(launch_vy),
    .tick_i(tick_act), .dv_en_i(tick_act), .dv_i(GV),
    .pos_o(y_q), .pos_nxt_o(y_n), .vel_nxt_o(vy_n)
  );
  // Retire is judged on the post-tick state so done lands on the same tick that leaves the screen.
  always_comb begin
    tick_act  = frame_tick && state_q != IDLE;
    ld        = launch && state_q == IDLE;
    split_now = cut && state_q == WHOLE;
    fall      = y_n >= SH && !vy_n[VEL_W-1] && vy_n != '0;
    gone      = off_x(x1_n, SW) && off_x(x2_n, SW);
    retire    = tick_act && (fall || (state_q == SPLIT && gone));
    done_d    = retire;
    missed_d  = retire && state_q == WHOLE;
    state_d   = retire ? IDLE : ld ? WHOLE : split_now ? SPLIT : state_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign missed = missed_q;
  assign en1    = busy && !y_q[POS_W-1] && (state_q == WHOLE || !off_x(x1_q, SW));
  assign en2    = busy && !y_q[POS_W-1] && (state_q == WHOLE || !off_x(x2_q, SW));
  assign posx1  = clamp10(x1_q);
  assign posx2  = clamp10(x2_q);
  assign posy1  = clamp10(y_q);
  assign posy2  = clamp10(y_q);
endmodule

// File: tb/tb_fruit_slice_sequencer.sv
// tb_fruit_slice_sequencer: directed self-checking bench for fruit_slice_sequencer
module tb_fruit_slice_sequencer;
  logic clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, launch = 1'b0, cut = 1'b0;
  logic [9:0] launch_x = '0;
  logic signed [7:0] launch_vx = '0, launch_vy = '0;
  logic en1, en2, busy, done, missed;
  logic [9:0] posx1, posx2, posy1, posy2;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  fruit_slice_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch(launch), .launch_x(launch_x),
    .launch_vx(launch_vx), .launch_vy(launch_vy), .cut(cut), .en1(en1), .en2(en2),
    .posx1(posx1), .posx2(posx2), .posy1(posy1), .posy2(posy2), .busy(busy), .done(done), .missed(missed)
  );
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask
  task automatic fire(input logic [9:0] x, input logic signed [7:0] vx, input logic signed [7:0] vy);
    @(negedge clk);
    launch_x = x; launch_vx = vx; launch_vy = vy; launch = 1'b1;
    @(negedge clk) launch = 1'b0;
  endtask
  task automatic slash();
    @(negedge clk) cut = 1'b1;
    @(negedge clk) cut = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({en1, en2, busy, done, missed} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {en1, en2, busy, done, missed}); else passed++;
    total++; if ({posx1, posx2, posy1, posy2} !== 40'd0) $display("FAIL reset_pos: got %0d,%0d,%0d,%0d want 0,0,0,0", posx1, posx2, posy1, posy2); else passed++;
    rst = 1'b0;
  endtask
  task automatic test_cut_idle();
    slash();
    total++; if ({busy, en1, en2} !== 3'b0) $display("FAIL cut_idle: got busy/en %b want 000", {busy, en1, en2}); else passed++;
    tick();
    total++; if ({busy, done} !== 2'b0) $display("FAIL tick_idle: got busy/done %b want 00", {busy, done}); else passed++;
  endtask
  task automatic test_launch_miss();
    int ey;
    fire(10'd100, 8'sd0, -8'sd20);
    total++; if ({busy, en1, en2} !== 3'b111) $display("FAIL miss_launch_en: got %b want 111", {busy, en1, en2}); else passed++;
    total++; if (posy1 !== 10'd479 || posy2 !== 10'd479) $display("FAIL miss_launch_y: got %0d/%0d want 479", posy1, posy2); else passed++;
    for (int k = 1; k <= 44; k++) begin
      tick();
      total++; if (done !== 1'b0) $display("FAIL miss_early_done k=%0d: got %b want 0", k, done); else passed++;
      total++; if ({posx1, posx2} !== {10'd100, 10'd132}) $display("FAIL miss_x k=%0d: got %0d/%0d want 100/132", k, posx1, posx2); else passed++;
      case (k)
        1: ey = 459; 2: ey = 440; 3: ey = 422; 32: ey = 335; 33: ey = 347; 34: ey = 359; 44: ey = 479;
        default: ey = -1;
      endcase
      if (ey >= 0) begin
        total++; if (posy1 !== 10'(ey)) $display("FAIL miss_y k=%0d: got %0d want %0d", k, posy1, ey); else passed++;
      end
    end
    @(negedge clk);
    frame_tick = 1'b1; launch = 1'b1; launch_x = 10'd7;
    @(negedge clk);
    frame_tick = 1'b0; launch = 1'b0;
    total++; if ({done, missed} !== 2'b11) $display("FAIL miss_retire: got done/missed %b want 11", {done, missed}); else passed++;
    total++; if ({busy, en1, en2} !== 3'b0) $display("FAIL miss_idle: got busy/en %b want 000", {busy, en1, en2}); else passed++;
    @(negedge clk);
    total++; if ({done, missed, busy} !== 3'b0) $display("FAIL miss_pulse_launch_drop: got done/missed/busy %b want 000", {done, missed, busy}); else passed++;
  endtask
  task automatic test_cut();
    fire(10'd300, 8'sd1, -8'sd15);
    repeat (5) tick();
    total++; if ({posx1, posx2, posy1} !== {10'd305, 10'd337, 10'd414}) $display("FAIL cut_pre: got %0d/%0d/%0d want 305/337/414", posx1, posx2, posy1); else passed++;
    slash();
    total++; if ({busy, posx1, posx2} !== {1'b1, 10'd305, 10'd337}) $display("FAIL cut_hold: got %b %0d/%0d want 1 305/337", busy, posx1, posx2); else passed++;
    for (int k = 6; k <= 31; k++) begin
      tick();
      total++; if (done !== 1'b0) $display("FAIL cut_early_done k=%0d: got %b want 0", k, done); else passed++;
      if (k == 6) begin
        total++; if ({posx1, posx2} !== {10'd304, 10'd340}) $display("FAIL cut_k6: got %0d/%0d want 304/340", posx1, posx2); else passed++;
      end
      if (k == 7) begin
        total++; if ({posx1, posx2} !== {10'd303, 10'd343}) $display("FAIL cut_k7: got %0d/%0d want 303/343", posx1, posx2); else passed++;
      end
      if (k == 27) begin
        total++; if (posy1 !== 10'd425) $display("FAIL cut_y27: got %0d want 425", posy1); else passed++;
      end
    end
    total++; if ({posx1, posx2, posy1} !== {10'd279, 10'd415, 10'd473}) $display("FAIL cut_k31: got %0d/%0d/%0d want 279/415/473", posx1, posx2, posy1); else passed++;
    total++; if ({en1, en2} !== 2'b11) $display("FAIL cut_en31: got %b want 11", {en1, en2}); else passed++;
    tick();
    total++; if ({done, missed, busy} !== 3'b100) $display("FAIL cut_retire: got done/missed/busy %b want 100", {done, missed, busy}); else passed++;
  endtask
  task automatic test_side_exit();
    fire(10'd600, 8'sd10, -8'sd10);
    slash();
    tick();
    total++; if ({en1, en2, busy} !== 3'b101) $display("FAIL side_t1_en: got en1/en2/busy %b want 101", {en1, en2, busy}); else passed++;
    total++; if ({posx1, posx2, posy1} !== {10'd608, 10'd644, 10'd469}) $display("FAIL side_t1_pos: got %0d/%0d/%0d want 608/644/469", posx1, posx2, posy1); else passed++;
    repeat (3) tick();
    total++; if ({en1, en2, done} !== 3'b100) $display("FAIL side_t4: got en1/en2/done %b want 100", {en1, en2, done}); else passed++;
    total++; if ({posx1, posx2} !== {10'd632, 10'd680}) $display("FAIL side_t4_pos: got %0d/%0d want 632/680", posx1, posx2); else passed++;
    tick();
    total++; if ({done, missed, busy, en1} !== 4'b1000) $display("FAIL side_retire: got done/missed/busy/en1 %b want 1000", {done, missed, busy, en1}); else passed++;
  endtask
  task automatic test_collisions();
    fire(10'd200, 8'sd4, -8'sd10);
    tick();
    total++; if ({posx1, posx2, posy1} !== {10'd204, 10'd236, 10'd469}) $display("FAIL coll_t1: got %0d/%0d/%0d want 204/236/469", posx1, posx2, posy1); else passed++;
    @(negedge clk);
    cut = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    cut = 1'b0; frame_tick = 1'b0;
    total++; if ({posx1, posx2, posy1} !== {10'd208, 10'd240, 10'd460}) $display("FAIL coll_cut_tick: got %0d/%0d/%0d want 208/240/460", posx1, posx2, posy1); else passed++;
    tick();
    total++; if ({posx1, posx2} !== {10'd210, 10'd246}) $display("FAIL coll_split_v: got %0d/%0d want 210/246", posx1, posx2); else passed++;
    fire(10'd5, 8'sd0, 8'sd0);
    total++; if ({busy, posx1, posy1} !== {1'b1, 10'd210, 10'd452}) $display("FAIL coll_launch_busy: got %b %0d/%0d want 1 210/452", busy, posx1, posy1); else passed++;
    slash();
    tick();
    total++; if ({posx1, posx2, posy1} !== {10'd212, 10'd252, 10'd445}) $display("FAIL coll_cut_split: got %0d/%0d/%0d want 212/252/445", posx1, posx2, posy1); else passed++;
    do_reset();
  endtask
  task automatic test_negative_y();
    fire(10'd10, 8'sd0, 8'sh80);
    repeat (3) tick();
    total++; if ({posy1, en1} !== {10'd98, 1'b1}) $display("FAIL negy_t3: got y=%0d en1=%b want 98 1", posy1, en1); else passed++;
    tick();
    total++; if ({posy1, posy2} !== 20'd0) $display("FAIL negy_clamp: got %0d/%0d want 0/0", posy1, posy2); else passed++;
    total++; if ({en1, en2, busy} !== 3'b001) $display("FAIL negy_en: got en1/en2/busy %b want 001", {en1, en2, busy}); else passed++;
    total++; if (posx1 !== 10'd10) $display("FAIL negy_x: got %0d want 10", posx1); else passed++;
    do_reset();
  endtask
  task automatic test_rst_midflight();
    fire(10'd50, 8'sd0, -8'sd10);
    slash();
    tick();
    total++; if ({busy, en1, en2} !== 3'b111) $display("FAIL rst_pre: got busy/en %b want 111", {busy, en1, en2}); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if ({en1, en2, busy, done, missed} !== 5'b0) $display("FAIL rst_async: got %b want 00000", {en1, en2, busy, done, missed}); else passed++;
    total++; if (posx1 !== 10'd0) $display("FAIL rst_pos: got %0d want 0", posx1); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL rst_no_done k=%0d: got %b want 0", k, done); else passed++;
    end
    rst = 1'b0;
    fire(10'd100, 8'sd0, -8'sd20);
    total++; if ({busy, en1, en2, posx1, posx2, posy1} !== {3'b111, 10'd100, 10'd132, 10'd479}) $display("FAIL rst_relaunch: got %b %0d/%0d/%0d want 111 100/132/479", {busy, en1, en2}, posx1, posx2, posy1); else passed++;
    tick();
    total++; if (posy1 !== 10'd459) $display("FAIL rst_relaunch_tick: got %0d want 459", posy1); else passed++;
    do_reset();
  endtask
  initial begin
    test_reset();
    test_cut_idle();
    test_launch_miss();
    test_cut();
    test_side_exit();
    test_collisions();
    test_negative_y();
    test_rst_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
